// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: default operand width, FSM states, counter width.
package muldiv_pkg;
  localparam int MUL_WIDTH = 6;
  localparam int CNT_W     = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mul_add_cell.sv
// One-bit partial-product cell: gates the multiplicand bit with the current multiplier LSB
// and adds it into the accumulator bit with ripple carry.
module mul_add_cell (
  input  logic m,
  input  logic sel,
  input  logic x,
  input  logic cin,
  output logic s,
  output logic co
);
  logic pp;

  assign pp = m & sel;
  assign s  = x ^ pp ^ cin;
  assign co = (x & pp) | (x & cin) | (pp & cin);
endmodule

// File: rtl/seq_mul_unit.sv
// Sequential shift-and-add multiplier, one add row per clock, WIDTH iterations per operation.
// Optional MUL_SIGNED_EN adds an in_signed port for two's-complement operands.
module seq_mul_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc, acc_nx, acc_fin;
  logic [CW-1:0]      cnt;
  logic               last;
  logic [WIDTH:0]     c;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign c[0] = 1'b0;

  // Add row: upper half of acc plus (mcand & acc[0]); carry-out becomes the new MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    mul_add_cell u_cell (
      .m   (mcand[i]),
      .sel (acc[0]),
      .x   (acc[WIDTH+i]),
      .cin (c[i]),
      .s   (sum[i]),
      .co  (c[i+1])
    );
  end

  assign acc_nx = {c[WIDTH], sum, acc[WIDTH-1:1]};
  assign last   = (cnt == CW'(WIDTH - 1));
  assign p      = acc;

`ifdef MUL_SIGNED_EN
  logic sgn_a, sgn_b, neg;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign sgn_a   = in_signed & a[WIDTH-1];
  assign sgn_b   = in_signed & b[WIDTH-1];
  assign a_mag   = sgn_a ? -a : a;
  assign b_mag   = sgn_b ? -b : b;
  assign acc_fin = neg ? -acc_nx : acc_nx;

  always_ff @(posedge clk) begin
    if (reset)                            neg <= 1'b0;
    else if (state == IDLE && in_valid)   neg <= sgn_a ^ sgn_b;
  end
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign acc_fin = acc_nx;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand <= a_mag;
          acc   <= {{WIDTH{1'b0}}, b_mag};
          cnt   <= '0;
        end
        RUN: begin
          acc <= last ? acc_fin : acc_nx;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul_unit.sv
// Randomized + directed bench for seq_mul_unit against a cycle-count/arithmetic reference model.
module tb_seq_mul_unit;
  localparam int W = 6;
`ifdef MUL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] p;
  logic           busy;

  int checks = 0;
  int fails  = 0;

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MUL_SIGNED_EN
    .in_signed (in_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    int sx, sy;
    sx = (s && SGN && x[W-1]) ? int'(x) - (1 << W) : int'(x);
    sy = (s && SGN && y[W-1]) ? int'(y) - (1 << W) : int'(y);
    return (2*W)'(sx * sy);
  endfunction

  // Reference model: one op in flight, result due WIDTH edges after the accepting edge.
  bit             pending = 1'b0;
  int             cyc = 0, acc_cyc = 0;
  logic [2*W-1:0] exp_p = '0, last_p = '0;

  always @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      last_p  <= '0;
    end else if (pending && (cyc - acc_cyc) > W) begin
      if (out_ready) begin
        pending <= 1'b0;
        last_p  <= exp_p;
      end
    end else if (!pending && in_valid) begin
      pending <= 1'b1;
      acc_cyc <= cyc;
      exp_p   <= ref_mul(a, b, in_signed);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int age;
    if (!reset) begin
      age = cyc - acc_cyc;
      chk("in_ready", 32'(in_ready), 32'(!pending));
      chk("busy", 32'(busy), 32'(pending && age <= W));
      chk("out_valid", 32'(out_valid), 32'(pending && age > W));
      if (pending && age > W) chk("p", 32'(p), 32'(exp_p));
      else if (!pending)      chk("p_hold", 32'(p), 32'(last_p));
    end
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                    input int stall, input logic [2*W-1:0] lit, input string nm);
    int n, nb;
    @(posedge clk); #1;
    a = x; b = y; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); in_signed = 1'($urandom);
    n = 0; nb = int'(busy);
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; nb += int'(busy); end
    chk({nm, "_lat"}, 32'(n), 32'(W));
    chk({nm, "_busy"}, 32'(nb), 32'(W));
    chk({nm, "_lit"}, 32'(p), 32'(lit));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({nm, "_stall"}, {30'd0, out_valid, in_ready}, 32'b10);
      chk({nm, "_stall_p"}, 32'(p), 32'(lit));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_taken"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [2*W-1:0] got [2];
    int ng, n;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rst_p", 32'(p), 32'h0);

    op(6'd63, 6'd63, 1'b0, 0, 12'hF81, "m63x63");
    op(6'd0,  6'd45, 1'b0, 0, 12'h000, "m0x45");
    op(6'd45, 6'd0,  1'b0, 0, 12'h000, "m45x0");
    op(6'd1,  6'd37, 1'b0, 0, 12'h025, "m1x37");
    op(6'd12, 6'd11, 1'b0, 5, 12'h084, "m12x11");

    // Reset on the third RUN cycle discards the operation.
    @(posedge clk); #1;
    a = 6'd50; b = 6'd50; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midrun_rst", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("midrun_rst_p", 32'(p), 32'h0);
    op(6'd3, 6'd4, 1'b0, 0, 12'h00C, "m3x4");

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    a = 6'd5; b = 6'd7; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 6'd9; b = 6'd9;
    ng = 0; n = 0;
    while (!(ng == 2 && !out_valid) && n < 60) begin
      if (out_valid && ng < 2) begin got[ng] = p; ng++; end
      if (ng == 1 && busy) in_valid = 1'b0;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 32'(ng), 32'd2);
    chk("b2b_first", 32'(got[0]), 32'h023);
    chk("b2b_second", 32'(got[1]), 32'h051);

`ifdef MUL_SIGNED_EN
    op(6'h20, 6'h20, 1'b1, 0, 12'h400, "s_m32xm32");
    op(6'h3F, 6'd5,  1'b1, 0, 12'hFFB, "s_m1x5");
    op(6'd31, 6'h20, 1'b1, 0, 12'hC20, "s_31xm32");
    op(6'd63, 6'd63, 1'b0, 0, 12'hF81, "s_off63x63");
`endif

    // Random traffic, checked every cycle by the compare process.
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 3) != 0;
      a         = W'($urandom);
      b         = W'($urandom);
      in_signed = 1'($urandom);
      out_ready = 1'($urandom);
      if (k == 400) reset = 1'b1;
      else          reset = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_idle", {30'd0, in_ready, out_valid}, 32'b10);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
